// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder-buffer retirement controller.
package rob_pkg;

  localparam int unsigned AREG_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PC_W   = 32;

  localparam logic [PC_W-1:0] TRAP_VEC_DEFAULT = 32'h0000_0100;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } retire_state_e;

endpackage

// File: rtl/rob_retire_if.sv
// ROB head window and store-commit handshake between the ROB and the retire controller.
interface rob_retire_if #(
  parameter int unsigned RETIRE_WIDTH = 2
) ();
  import rob_pkg::*;

  localparam int unsigned CNT_W = $clog2(RETIRE_WIDTH + 1);

  logic [RETIRE_WIDTH-1:0]        head_valid;
  logic [RETIRE_WIDTH-1:0]        head_done;
  logic [RETIRE_WIDTH-1:0]        head_exc;
  logic [RETIRE_WIDTH-1:0]        head_store;
  logic [RETIRE_WIDTH-1:0]        head_rd_we;
  logic [RETIRE_WIDTH*AREG_W-1:0] head_rd;
  logic [RETIRE_WIDTH*DATA_W-1:0] head_data;
  logic [RETIRE_WIDTH*PC_W-1:0]   head_pc;
  logic                           store_commit_ready;
  logic [CNT_W-1:0]               retire_cnt;
  logic                           store_commit_valid;

  modport master (
    output head_valid, head_done, head_exc, head_store, head_rd_we,
           head_rd, head_data, head_pc, store_commit_ready,
    input  retire_cnt, store_commit_valid
  );

  modport slave (
    input  head_valid, head_done, head_exc, head_store, head_rd_we,
           head_rd, head_data, head_pc, store_commit_ready,
    output retire_cnt, store_commit_valid
  );

endinterface

// File: rtl/rob_retire_select.sv
// Combinational retire-prefix selection: retire mask/count, single store grant, exception slot.
module rob_retire_select #(
  parameter int unsigned RETIRE_WIDTH = 2,
  parameter int unsigned CNT_W        = $clog2(RETIRE_WIDTH + 1),
  parameter int unsigned IDX_W        = (RETIRE_WIDTH > 1) ? $clog2(RETIRE_WIDTH) : 1
) (
  input  logic [RETIRE_WIDTH-1:0] i_valid,
  input  logic [RETIRE_WIDTH-1:0] i_done,
  input  logic [RETIRE_WIDTH-1:0] i_exc,
  input  logic [RETIRE_WIDTH-1:0] i_store,
  input  logic                    i_store_ready,
  output logic [RETIRE_WIDTH-1:0] o_mask,
  output logic [CNT_W-1:0]        o_cnt,
  output logic                    o_store_grant,
  output logic                    o_exc_hit,
  output logic [IDX_W-1:0]        o_exc_idx
);

  logic w_stop;
  logic w_store_seen;

  // Walk oldest to youngest; the first slot that cannot retire ends the prefix.
  always_comb begin
    o_mask       = '0;
    o_cnt        = '0;
    o_exc_hit    = 1'b0;
    o_exc_idx    = '0;
    w_stop       = 1'b0;
    w_store_seen = 1'b0;
    for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
      if (!w_stop) begin
        if (i_valid[i] && i_done[i] && !i_exc[i] &&
            (!i_store[i] || (i_store_ready && !w_store_seen))) begin
          o_mask[i]    = 1'b1;
          o_cnt        = o_cnt + CNT_W'(1);
          w_store_seen = w_store_seen | i_store[i];
        end else begin
          w_stop = 1'b1;
          if (i_valid[i] && i_done[i] && i_exc[i]) begin
            o_exc_hit = 1'b1;
            o_exc_idx = IDX_W'(i);
          end
        end
      end
    end
    o_store_grant = w_store_seen;
  end

endmodule

// File: rtl/rob_retire_ctrl.sv
// In-order retirement FSM (RUN/FLUSH/DRAIN), register-file write stage and exception redirect.
// Optional perf counters are built only when ROB_RETIRE_PERF_EN is defined.
module rob_retire_ctrl
  import rob_pkg::*;
#(
  parameter int unsigned      RETIRE_WIDTH = 2,
  parameter logic [PC_W-1:0]  TRAP_VEC     = TRAP_VEC_DEFAULT,
  parameter int unsigned      FLUSH_DRAIN  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  rob_retire_if.slave                    bus,
  output logic [RETIRE_WIDTH-1:0]        areg_we,
  output logic [RETIRE_WIDTH*AREG_W-1:0] areg_addr,
  output logic [RETIRE_WIDTH*DATA_W-1:0] areg_data,
  output logic                           flush,
  output logic                           redirect_valid,
  output logic [PC_W-1:0]                redirect_pc,
  output logic [PC_W-1:0]                epc,
  output logic [31:0]                    retired_total,
  output logic [31:0]                    stall_cycles
);

  localparam int unsigned CNT_W = $clog2(RETIRE_WIDTH + 1);
  localparam int unsigned IDX_W = (RETIRE_WIDTH > 1) ? $clog2(RETIRE_WIDTH) : 1;
  localparam int unsigned DRN_W = (FLUSH_DRAIN > 1) ? $clog2(FLUSH_DRAIN) : 1;

  retire_state_e             r_state;
  logic [DRN_W-1:0]          r_drain_cnt;
  logic [RETIRE_WIDTH-1:0]   r_areg_we;
  logic [RETIRE_WIDTH*AREG_W-1:0] r_areg_addr;
  logic [RETIRE_WIDTH*DATA_W-1:0] r_areg_data;
  logic                      r_flush;
  logic [PC_W-1:0]           r_redirect_pc;
  logic [PC_W-1:0]           r_epc;

  logic [RETIRE_WIDTH-1:0]   w_mask;
  logic [CNT_W-1:0]          w_cnt;
  logic                      w_store_grant;
  logic                      w_exc_hit;
  logic [IDX_W-1:0]          w_exc_idx;
  logic [PC_W-1:0]           w_exc_pc;
  logic                      w_run;

  rob_retire_select #(
    .RETIRE_WIDTH (RETIRE_WIDTH),
    .CNT_W        (CNT_W),
    .IDX_W        (IDX_W)
  ) u_select (
    .i_valid       (bus.head_valid),
    .i_done        (bus.head_done),
    .i_exc         (bus.head_exc),
    .i_store       (bus.head_store),
    .i_store_ready (bus.store_commit_ready),
    .o_mask        (w_mask),
    .o_cnt         (w_cnt),
    .o_store_grant (w_store_grant),
    .o_exc_hit     (w_exc_hit),
    .o_exc_idx     (w_exc_idx)
  );

  assign w_run                  = (r_state == RUN);
  assign bus.retire_cnt         = w_run ? w_cnt : '0;
  assign bus.store_commit_valid = w_run & w_store_grant;

  always_comb begin
    w_exc_pc = '0;
    for (int unsigned k = 0; k < RETIRE_WIDTH; k++) begin
      if (IDX_W'(k) == w_exc_idx) w_exc_pc = bus.head_pc[k*PC_W +: PC_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_drain_cnt   <= '0;
      r_flush       <= 1'b0;
      r_redirect_pc <= '0;
      r_epc         <= '0;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        RUN: begin
          if (w_exc_hit) begin
            r_state       <= FLUSH;
            r_flush       <= 1'b1;
            r_redirect_pc <= TRAP_VEC;
            r_epc         <= w_exc_pc;
          end
        end
        FLUSH: begin
          r_state     <= DRAIN;
          r_drain_cnt <= '0;
        end
        DRAIN: begin
          if (r_drain_cnt == DRN_W'(FLUSH_DRAIN - 1)) begin
            r_state     <= RUN;
            r_drain_cnt <= '0;
          end else begin
            r_drain_cnt <= r_drain_cnt + DRN_W'(1);
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Writes to x0 are dropped here so the register file never sees them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_areg_we   <= '0;
      r_areg_addr <= '0;
      r_areg_data <= '0;
    end else begin
      for (int unsigned k = 0; k < RETIRE_WIDTH; k++) begin
        r_areg_we[k] <= w_run && w_mask[k] && bus.head_rd_we[k] &&
                        (bus.head_rd[k*AREG_W +: AREG_W] != '0);
        if (w_run && w_mask[k]) begin
          r_areg_addr[k*AREG_W +: AREG_W] <= bus.head_rd[k*AREG_W +: AREG_W];
          r_areg_data[k*DATA_W +: DATA_W] <= bus.head_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign areg_we        = r_areg_we;
  assign areg_addr      = r_areg_addr;
  assign areg_data      = r_areg_data;
  assign flush          = r_flush;
  assign redirect_valid = r_flush;
  assign redirect_pc    = r_redirect_pc;
  assign epc            = r_epc;

`ifdef ROB_RETIRE_PERF_EN
  logic [31:0] r_retired_total;
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired_total <= '0;
      r_stall_cycles  <= '0;
    end else begin
      r_retired_total <= r_retired_total + 32'(bus.retire_cnt);
      if (w_run && bus.head_valid[0] && (bus.retire_cnt == '0))
        r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign retired_total = r_retired_total;
  assign stall_cycles  = r_stall_cycles;
`else
  assign retired_total = '0;
  assign stall_cycles  = '0;
`endif

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Self-checking bench for rob_retire_ctrl: vector table with a register-write scoreboard plus exception/reset sequences.
module tb_rob_retire_ctrl;
  import rob_pkg::*;

  localparam int unsigned RW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rob_retire_if #(.RETIRE_WIDTH(RW)) bus ();

  logic [RW-1:0]        areg_we;
  logic [RW*AREG_W-1:0] areg_addr;
  logic [RW*DATA_W-1:0] areg_data;
  logic                 flush;
  logic                 redirect_valid;
  logic [PC_W-1:0]      redirect_pc;
  logic [PC_W-1:0]      epc;
  logic [31:0]          retired_total;
  logic [31:0]          stall_cycles;

  rob_retire_ctrl #(
    .RETIRE_WIDTH (RW),
    .TRAP_VEC     (32'h0000_0100),
    .FLUSH_DRAIN  (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .areg_we        (areg_we),
    .areg_addr      (areg_addr),
    .areg_data      (areg_data),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .epc            (epc),
    .retired_total  (retired_total),
    .stall_cycles   (stall_cycles)
  );

  typedef struct {
    logic [1:0]  valid, done, store, rd_we;
    logic [4:0]  rd0, rd1;
    logic [31:0] d0, d1;
    logic        ready;
    logic [1:0]  exp_cnt;
    logic        exp_scv;
    logic [1:0]  exp_we;
  } vec_t;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
  } wr_exp_t;

  vec_t    vecs[10];
  wr_exp_t sb[$];
  int      n_checks = 0;
  int      n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] d, input logic [1:0] e,
                       input logic [1:0] s, input logic [1:0] we,
                       input logic [4:0] r0, input logic [4:0] r1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] pc0, input logic [31:0] pc1, input logic rdy);
    bus.head_valid         = v;
    bus.head_done          = d;
    bus.head_exc           = e;
    bus.head_store         = s;
    bus.head_rd_we         = we;
    bus.head_rd            = {r1, r0};
    bus.head_data          = {d1, d0};
    bus.head_pc            = {pc1, pc0};
    bus.store_commit_ready = rdy;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic check_writes(input string nm);
    wr_exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({nm, ".we"}, 64'(areg_we), 64'(e.we));
    if (e.we[0]) begin
      chk({nm, ".addr0"}, 64'(areg_addr[4:0]), 64'(e.a0));
      chk({nm, ".data0"}, 64'(areg_data[31:0]), 64'(e.d0));
    end
    if (e.we[1]) begin
      chk({nm, ".addr1"}, 64'(areg_addr[9:5]), 64'(e.a1));
      chk({nm, ".data1"}, 64'(areg_data[63:32]), 64'(e.d1));
    end
  endtask

  initial begin
    //          valid  done   store  rd_we  rd0 rd1  d0     d1     rdy cnt scv we
    vecs[0] = '{2'b11, 2'b11, 2'b00, 2'b11, 5'd3, 5'd7, 32'hA, 32'hB, 1'b1, 2'd2, 1'b0, 2'b11};
    vecs[1] = '{2'b11, 2'b01, 2'b00, 2'b11, 5'd1, 5'd2, 32'h11, 32'h22, 1'b1, 2'd1, 1'b0, 2'b01};
    vecs[2] = '{2'b11, 2'b10, 2'b00, 2'b11, 5'd1, 5'd2, 32'h11, 32'h22, 1'b1, 2'd0, 1'b0, 2'b00};
    vecs[3] = '{2'b11, 2'b11, 2'b11, 2'b00, 5'd4, 5'd5, 32'h1, 32'h2, 1'b1, 2'd1, 1'b1, 2'b00};
    vecs[4] = '{2'b11, 2'b11, 2'b11, 2'b00, 5'd4, 5'd5, 32'h1, 32'h2, 1'b0, 2'd0, 1'b0, 2'b00};
    vecs[5] = '{2'b01, 2'b01, 2'b00, 2'b01, 5'd0, 5'd6, 32'h77, 32'h0, 1'b1, 2'd1, 1'b0, 2'b00};
    vecs[6] = '{2'b11, 2'b11, 2'b01, 2'b10, 5'd8, 5'd9, 32'h5, 32'hC0DE, 1'b1, 2'd2, 1'b1, 2'b10};
    vecs[7] = '{2'b00, 2'b11, 2'b00, 2'b11, 5'd1, 5'd2, 32'h3, 32'h4, 1'b1, 2'd0, 1'b0, 2'b00};
    vecs[8] = '{2'b01, 2'b11, 2'b00, 2'b11, 5'd31, 5'd2, 32'hDEAD, 32'h4, 1'b1, 2'd1, 1'b0, 2'b01};
    vecs[9] = '{2'b11, 2'b11, 2'b10, 2'b11, 5'd12, 5'd13, 32'h66, 32'h99, 1'b0, 2'd1, 1'b0, 2'b01};

    rst = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.areg_we", 64'(areg_we), 64'd0);
    chk("rst.flush", 64'(flush), 64'd0);
    chk("rst.redirect_valid", 64'(redirect_valid), 64'd0);
    chk("rst.redirect_pc", 64'(redirect_pc), 64'd0);
    chk("rst.epc", 64'(epc), 64'd0);
    chk("rst.retired_total", 64'(retired_total), 64'd0);
    chk("rst.stall_cycles", 64'(stall_cycles), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      wr_exp_t e;
      @(posedge clk); #1;
      check_writes($sformatf("vec%0d_prev", i));
      drive(vecs[i].valid, vecs[i].done, 2'b00, vecs[i].store, vecs[i].rd_we,
            vecs[i].rd0, vecs[i].rd1, vecs[i].d0, vecs[i].d1, 32'd0, 32'd0, vecs[i].ready);
      #1;
      chk($sformatf("vec%0d.retire_cnt", i), 64'(bus.retire_cnt), 64'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d.store_commit_valid", i), 64'(bus.store_commit_valid), 64'(vecs[i].exp_scv));
      e.we = vecs[i].exp_we;
      e.a0 = vecs[i].rd0;
      e.a1 = vecs[i].rd1;
      e.d0 = vecs[i].d0;
      e.d1 = vecs[i].d1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    check_writes("vec_last");
    idle();

    // Exception on slot 1 with slot 0 retiring.
    @(posedge clk); #1;
    drive(2'b11, 2'b11, 2'b10, 2'b00, 2'b01, 5'd4, 5'd0, 32'h5, 32'h0, 32'h3C, 32'h40, 1'b1);
    #1;
    chk("exc.retire_cnt", 64'(bus.retire_cnt), 64'd1);
    chk("exc.store_commit_valid", 64'(bus.store_commit_valid), 64'd0);
    @(posedge clk); #1;
    chk("flush.flush", 64'(flush), 64'd1);
    chk("flush.redirect_valid", 64'(redirect_valid), 64'd1);
    chk("flush.redirect_pc", 64'(redirect_pc), 64'h100);
    chk("flush.epc", 64'(epc), 64'h40);
    chk("flush.areg_we", 64'(areg_we), 64'b01);
    chk("flush.areg_addr0", 64'(areg_addr[4:0]), 64'd4);
    chk("flush.areg_data0", 64'(areg_data[31:0]), 64'h5);
    drive(2'b11, 2'b11, 2'b00, 2'b01, 2'b11, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 32'h0, 1'b1);
    #1;
    chk("flush.retire_cnt", 64'(bus.retire_cnt), 64'd0);
    chk("flush.store_commit_valid", 64'(bus.store_commit_valid), 64'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #2;
      chk($sformatf("drain%0d.retire_cnt", c), 64'(bus.retire_cnt), 64'd0);
      chk($sformatf("drain%0d.store_commit_valid", c), 64'(bus.store_commit_valid), 64'd0);
      chk($sformatf("drain%0d.flush", c), 64'(flush), 64'd0);
      chk($sformatf("drain%0d.redirect_valid", c), 64'(redirect_valid), 64'd0);
      chk($sformatf("drain%0d.areg_we", c), 64'(areg_we), 64'd0);
    end
    @(posedge clk); #2;
    chk("rerun.retire_cnt", 64'(bus.retire_cnt), 64'd2);
    chk("rerun.store_commit_valid", 64'(bus.store_commit_valid), 64'd1);
    @(posedge clk); #1;
    chk("rerun.areg_we", 64'(areg_we), 64'b11);
    idle();

    // Exception on slot 0, then reset during the first DRAIN cycle.
    @(posedge clk); #1;
    drive(2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h80, 32'h0, 1'b1);
    #1;
    chk("exc0.retire_cnt", 64'(bus.retire_cnt), 64'd0);
    @(posedge clk); #1;
    chk("exc0.flush", 64'(flush), 64'd1);
    chk("exc0.epc", 64'(epc), 64'h80);
    drive(2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 5'd10, 5'd0, 32'h1234, 32'h0, 32'h0, 32'h0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rstdrain.retire_cnt", 64'(bus.retire_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("postrst.flush", 64'(flush), 64'd0);
    chk("postrst.areg_we", 64'(areg_we), 64'd0);
    chk("postrst.epc", 64'(epc), 64'd0);
    chk("postrst.retire_cnt", 64'(bus.retire_cnt), 64'd1);
    @(posedge clk); #1;
    chk("postrst.areg_we_next", 64'(areg_we), 64'b01);
    chk("postrst.areg_addr0", 64'(areg_addr[4:0]), 64'd10);
    chk("postrst.areg_data0", 64'(areg_data[31:0]), 64'h1234);
    idle();

`ifndef ROB_RETIRE_PERF_EN
    chk("perf_off.retired_total", 64'(retired_total), 64'd0);
    chk("perf_off.stall_cycles", 64'(stall_cycles), 64'd0);
`endif

    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rob_retire_ctrl.md
Name: rob_retire_ctrl

Overview:
- Sequences in-order retirement from the reorder buffer head window.
- Each cycle, decides how many head entries retire (0..RETIRE_WIDTH) and drives architectural register-file writes.
- Grants at most one store commit per cycle to the store buffer.
- On an excepting head entry, runs a flush/redirect sequence and holds retirement until the pipeline drains.

Parameters:
- RETIRE_WIDTH, 2, number of head slots examined/retired per cycle (slot 0 = oldest).
- AREG_W, 5, architectural register index width.
- DATA_W, 32, result data width.
- PC_W, 32, program counter width.
- TRAP_VEC, 32'h0000_0100, redirect target on exception.
- FLUSH_DRAIN, 2, cycles spent in DRAIN after the flush pulse (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- head_valid  in  RETIRE_WIDTH  slot holds an allocated entry.
- head_done  in  RETIRE_WIDTH  slot's result is written back.
- head_exc  in  RETIRE_WIDTH  slot raised an exception.
- head_store  in  RETIRE_WIDTH  slot is a store.
- head_rd_we  in  RETIRE_WIDTH  slot writes a destination register.
- head_rd  in  RETIRE_WIDTH*AREG_W  destination indices, packed by slot.
- head_data  in  RETIRE_WIDTH*DATA_W  results, packed by slot.
- head_pc  in  RETIRE_WIDTH*PC_W  PCs, packed by slot.
- store_commit_ready  in  1  store buffer can accept a commit.
- retire_cnt  out  $clog2(RETIRE_WIDTH+1)  entries the ROB pops this cycle (combinational).
- store_commit_valid  out  1  a store retires this cycle (combinational).
- areg_we  out  RETIRE_WIDTH  register write enables (registered).
- areg_addr  out  RETIRE_WIDTH*AREG_W  register write indices (registered).
- areg_data  out  RETIRE_WIDTH*DATA_W  register write data (registered).
- flush  out  1  pipeline flush pulse (registered).
- redirect_valid  out  1  fetch redirect (registered).
- redirect_pc  out  PC_W  redirect target.
- epc  out  PC_W  PC of the last excepting instruction.
- retired_total  out  32  perf counter (see Optional Feature).
- stall_cycles  out  32  perf counter (see Optional Feature).

Behaviour:
- Reset: state RUN; all outputs 0 (redirect_pc, epc, counters 0).
- FSM states: RUN, FLUSH, DRAIN.
- RUN, slot eligibility:
  - Slot i is eligible only if every slot j<i retires.
  - Slot i retires when valid & done & !exc, with the store rule below.
  - Store rule: a store retires only if store_commit_ready=1 and no earlier slot this cycle is a store.
  - retire_cnt = length of the contiguous retiring prefix.
  - store_commit_valid = 1 iff a retiring slot is a store.
- RUN, exception: first non-retiring slot i is valid & done & exc.
  - Slot i is not retired; retire_cnt = i.
  - epc <= head_pc[i].
  - Next state FLUSH.
- A not-done or invalid slot stops retirement silently; the FSM stays in RUN.
- Register writes:
  - Cycle after retirement: areg_we[k] = 1 for each retired slot k with rd_we=1 and rd!=0; addr/data carried.
  - Otherwise areg_we = 0.
- FLUSH (exactly 1 cycle): flush=1, redirect_valid=1, redirect_pc=TRAP_VEC, retire_cnt=0, store_commit_valid=0. Next state DRAIN.
- DRAIN:
  - Drain counter counts FLUSH_DRAIN cycles.
  - retire_cnt=0 and store_commit_valid=0 regardless of inputs.
  - Then RUN.
- Exception timing: detection at cycle T gives flush at T+1, RUN again at T+2+FLUSH_DRAIN.
- flush and redirect_valid are 0 outside FLUSH.
- Reset mid-FLUSH/DRAIN: next cycle RUN, flush=0, drain counter cleared, areg_we=0.

Optional Feature:
- Macro: ROB_RETIRE_PERF_EN.
- When defined:
  - retired_total += retire_cnt each cycle.
  - stall_cycles += 1 each RUN cycle where head_valid[0]=1 and retire_cnt=0.
  - Both counters wrap modulo 2^32 and are cleared by rst.
- When undefined: both ports are driven constant 0 and no counter flops exist.

Decomposition:
- Shared package rob_pkg:
  - retire_state_e enum (RUN/FLUSH/DRAIN).
  - AREG_W, DATA_W, PC_W constants.
  - TRAP_VEC default.
- Natural sub-module: rob_retire_select.
  - Purely combinational.
  - Takes the per-slot flags and store_commit_ready.
  - Produces the retire mask, retire_cnt, store grant, exception hit and exception slot index.
- rob_retire_ctrl keeps the FSM, drain counter, output registers and perf counters.

Test Plan:
- Both slots valid/done, rd=3/7, data=0xA/0xB -> retire_cnt=2 that cycle; next cycle areg_we=2'b11, addr 3/7, data 0xA/0xB.
- Slot0 done, slot1 valid not done -> retire_cnt=1; slot0 not done, slot1 done -> retire_cnt=0.
- Both slots stores, ready=1 -> retire_cnt=1, store_commit_valid=1; same with ready=0 -> retire_cnt=0, store_commit_valid=0.
- Slot0 retires, slot1 exc, pc1=0x40 -> retire_cnt=1; next cycle flush=1, redirect_pc=0x100, epc=0x40; then 2 cycles retire_cnt=0 with all-done inputs; RUN on the following cycle.
- Slot0 retires with rd=0, rd_we=1 -> retire_cnt=1, areg_we[0]=0 next cycle.
- rst asserted during the first DRAIN cycle -> next cycle state RUN, flush=0; valid/done slot0 retires immediately after rst deasserts.
